// File: rtl/tdm_pkg.sv
// Shared lane definitions for the 8:1 TDM mux and its matching 1:8 demux.
package tdm_pkg;

    localparam int N_LANES = 8;
    localparam int SEL_W   = 3;

    typedef logic [SEL_W-1:0] lane_idx_t;

    // Reset value of the round-robin pointer, chosen so that lane 0 is searched first.
    localparam lane_idx_t PTR_RESET = lane_idx_t'(N_LANES - 1);

endpackage

// File: rtl/rr_arb8.sv
// Combinational round-robin arbiter. It searches ptr+1 .. ptr+8 (mod 8) and
// grants the first requesting lane.
module rr_arb8
    import tdm_pkg::*;
(
    input  logic [N_LANES-1:0] req,
    input  lane_idx_t          ptr,
    output lane_idx_t          grant,
    output logic               any_req
);

    lane_idx_t idx;

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        // The 3-bit add wraps, so offset 8 lands back on ptr itself (searched last).
        for (int i = 1; i <= N_LANES; i++) begin
            idx = ptr + lane_idx_t'(i);
            if (!any_req && req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux8.sv
// Eight-lane round-robin TDM merge with one registered output stage and lane tags.
module tdm_mux8
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_LANES*W-1:0] in_data,
    input  logic [N_LANES-1:0]   in_valid,
    output logic [N_LANES-1:0]   in_ready,
    output logic [W-1:0]         out_data,
    output lane_idx_t            out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    lane_idx_t      ptr;
    lane_idx_t      grant;
    logic           any_req;
    logic           load_en;
    logic [W-1:0]   grant_data;

    rr_arb8 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    assign load_en    = !out_valid || out_ready;
    assign grant_data = in_data[int'(grant)*W +: W];

    // Ready is gated by reset so that no upstream word is consumed and then dropped.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && any_req) begin
            in_ready[grant] = 1'b1;
        end
    end

    // out_sel[2] drives demux s0, out_sel[0] drives s2.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= PTR_RESET;
        end else if (load_en) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant;
                ptr       <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux8.sv
// Bench for tdm_mux8: directed scenarios plus random traffic, checked against a
// transaction-level model and a per-lane scoreboard.
module tb_tdm_mux8;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [8*W-1:0]   in_data;
    logic [7:0]       in_valid;
    logic [7:0]       in_ready;
    logic [W-1:0]     out_data;
    logic [2:0]       out_sel;
    logic             out_valid;
    logic             out_ready;

    tdm_mux8 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: the word held at the output and the last lane served.
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_sel   = 0;
    int           m_last  = 7;

    logic [W-1:0] sb[8][$];
    int           waits[8];
    logic [7:0]   last_hs = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven (at the falling edge).
    task automatic tick();
        int         g;
        bit         found;
        bit         load;
        logic [7:0] exp_rdy;
        #1;
        found = 1'b0;
        g     = 0;
        load  = !m_valid || out_ready;
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (m_last + k) % 8;
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_rdy = '0;
        if (!rst && load && found) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));

        last_hs = in_valid & in_ready;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                sb[i].delete();
                waits[i] = 0;
            end
        end else begin
            if (out_valid && out_ready) begin
                if (sb[out_sel].size() == 0) chk("sb_underflow", 64'(1), 64'(0));
                else chk("sb_data", 64'(out_data), 64'(sb[out_sel].pop_front()));
            end
            for (int i = 0; i < 8; i++) begin
                if (last_hs[i]) sb[i].push_back(in_data[i*W +: W]);
                if (!in_valid[i]) waits[i] = 0;
                else if (last_hs[i]) begin
                    chk("max_wait", 64'(waits[i] <= 7), 64'(1));
                    waits[i] = 0;
                end else if (|last_hs) waits[i]++;
            end
        end

        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_last  = 7;
        end else if (load) begin
            if (found) begin
                m_valid = 1'b1;
                m_data  = in_data[g*W +: W];
                m_sel   = g;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_sel",   64'(out_sel),   64'(m_sel));
        chk("out_data",  64'(out_data),  64'(m_data));
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) in_data[i*W +: W] = W'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        rand_data();
        @(negedge clk);
        tick();
        tick();

        // All lanes busy: strict 0..7 rotation, first word one cycle after reset.
        rst       = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rand_data();
            tick();
            chk("rr_seq", 64'(out_sel), 64'(k % 8));
            chk("rr_valid", 64'(out_valid), 64'(1));
        end

        // Lane 5 alone.
        in_valid = 8'h20;
        in_data[5*W +: W] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("lane5_data", 64'(out_data), 64'(8'hA5));
            chk("lane5_sel", 64'(out_sel), 64'(3'b101));
        end

        // Lanes 2 and 6 with a four-cycle stall after the first load.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 8'h44;
        out_ready = 1'b0;
        rand_data();
        tick();
        chk("stall_first", 64'(out_sel), 64'(2));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stall_sel", 64'(out_sel), 64'(2));
            chk("stall_data", 64'(out_data), 64'(in_data[2*W +: W]));
        end
        out_ready = 1'b1;
        tick();
        chk("release_1", 64'(out_sel), 64'(6));
        tick();
        chk("release_2", 64'(out_sel), 64'(2));

        // Pointer wrap after lane 7.
        in_valid = 8'h80;
        tick();
        chk("wrap_7", 64'(out_sel), 64'(7));
        in_valid = 8'h09;
        tick();
        chk("wrap_0", 64'(out_sel), 64'(0));

        // Reset while a word is stalled.
        in_valid = 8'h10;
        tick();
        out_ready = 1'b0;
        tick();
        chk("held_sel", 64'(out_sel), 64'(4));
        rst = 1'b1;
        tick();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_sel", 64'(out_sel), 64'(0));
        rst       = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        tick();
        chk("rst_first", 64'(out_sel), 64'(0));

        // Random traffic.
        in_valid = '0;
        for (int n = 0; n < 10000; n++) begin
            for (int i = 0; i < 8; i++) begin
                if (last_hs[i] || !in_valid[i]) begin
                    in_valid[i] = ($urandom_range(0, 2) != 0);
                    in_data[i*W +: W] = W'($urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    in_valid[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_mux8.md
# tdm_mux8

Eight-lane round-robin time-division multiplexer that merges eight valid/ready input streams onto one output stream. Each output beat carries a 3-bit lane tag so the downstream 1:8 demultiplexer can route the word back to its lane. The block sits at the transmit end of the lane-merge path and owns fairness, back-pressure, and tag generation.

## Interface

- W, default 8: data width per lane and at the output.
- clk  in  1  rising-edge clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8*W  lane i occupies bits [i*W +: W].
- in_valid  in  8  per-lane word available.
- in_ready  out  8  per-lane accept; combinational, one-hot or zero.
- out_data  out  W  registered merged word.
- out_sel  out  3  registered binary lane index of out_data. Bit 2 maps to demux select s0, bit 1 to s1, bit 0 to s2.
- out_valid  out  1  registered; out_data and out_sel are meaningful.
- out_ready  in  1  downstream accept.

## Operation

- The output is a single register stage holding {out_data, out_sel, out_valid}.
- load_en = !out_valid | out_ready. The stage can take a new word this cycle.
- Arbitration uses a 3-bit round-robin pointer `ptr`, which is the last granted lane.
  - Search order: ptr+1, ptr+2, … ptr+8, mod 8.
  - Grant goes to the first lane with in_valid=1.
- When load_en=1 and any in_valid=1:
  - in_ready[grant]=1.
  - Next edge: out_data←lane data, out_sel←grant, out_valid←1, ptr←grant.
- When load_en=1 and no in_valid:
  - in_ready=0.
  - Next edge: out_valid←0. out_data, out_sel and ptr hold.
- When load_en=0 (stall):
  - in_ready=0.
  - out_data, out_sel, out_valid and ptr hold.
- in_ready never depends on out_valid of the same lane. No lane is granted twice while another valid lane waits. Worst-case wait is 7 grants.
- in_valid deasserting without a handshake is tolerated. That lane is skipped and no word is lost or duplicated.

## Timing

- Reset values: out_valid=0, out_data=0, out_sel=0, ptr=7 (lane 0 has first priority). in_ready=0 while rst=1.
- Latency: 1 cycle. An input handshake at edge n makes the word visible at the output after edge n.
- Throughput: one word per cycle when out_ready=1 continuously. This includes a back-to-back handshake and reload at the same edge.
- Simultaneous out_ready=1 and a new grant: the old word retires and the new word loads at the same edge, with no bubble.
- Pointer wrap: a grant of lane 7 makes lane 0 the next highest priority.
- Reset mid-stream: a held word is discarded and not re-issued. Inputs see in_ready=0 during reset.
- Stall: out_data and out_sel must stay stable while out_valid=1 and out_ready=0.

## Structure

- Shared package `tdm_pkg`:
  - N_LANES=8 and SEL_W=3.
  - lane-index type logic [SEL_W-1:0].
  - The demux reuses this package.
- Sub-module `rr_arb8`: combinational round-robin arbiter.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: grant index [2:0], any_req.
  - The top level holds the pointer and the output register.

## Test plan

- Reset, then all in_valid=1, out_ready=1 for 16 cycles -> out_sel sequence is 0,1,…,7,0,…,7. One in_ready pulse per cycle. The first out_valid appears one cycle after rst falls.
- Only lane 5 valid with data 8'hA5, out_ready=1 -> out_data=8'hA5 and out_sel=3'b101 every cycle. in_ready[5] stays high.
- Lanes 2 and 6 valid, out_ready held 0 for 4 cycles after the first load:
  - out_data and out_sel stay frozen.
  - in_ready=0 throughout.
  - On release, the next grant is lane 6, then lane 2.
- Lane 7 granted, then lanes 0 and 3 valid -> lane 0 is granted next (pointer wrap).
- rst pulsed while out_valid=1 with out_ready=0 -> after the reset edge, out_valid=0, out_sel=0, and the next grant starts from lane 0.
- Random in_valid and out_ready for 10k cycles, with a scoreboard per lane:
  - Every handshaken word appears exactly once, in order, with the correct out_sel.
  - No lane waits more than 7 grants.
